// File: rtl/seven_segment_pkg.sv
// Shared seven-segment definitions: segment patterns (bit0=a .. bit6=g),
// the blank pattern, and the decoder state encoding.
package seven_segment_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h67;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  localparam int unsigned CNT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

  localparam logic [3:0] DIGIT_INVALID = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } decoder_state_t;

endpackage

// File: rtl/seven_segment_lut.sv
// Combinational segment-pattern to digit lookup. Hex letters A..F are
// accepted only when SEVEN_SEGMENT_DECODER_HEX_EN is defined.
module seven_segment_lut
  import seven_segment_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic       valid_o,
  output logic [3:0] digit_o
);

  always_comb begin
    valid_o = 1'b1;
    digit_o = DIGIT_INVALID;
    case (seg_i)
      SEG_0:   digit_o = 4'h0;
      SEG_1:   digit_o = 4'h1;
      SEG_2:   digit_o = 4'h2;
      SEG_3:   digit_o = 4'h3;
      SEG_4:   digit_o = 4'h4;
      SEG_5:   digit_o = 4'h5;
      SEG_6:   digit_o = 4'h6;
      SEG_7:   digit_o = 4'h7;
      SEG_8:   digit_o = 4'h8;
      SEG_9:   digit_o = 4'h9;
`ifdef SEVEN_SEGMENT_DECODER_HEX_EN
      SEG_A:   digit_o = 4'hA;
      SEG_B:   digit_o = 4'hB;
      SEG_C:   digit_o = 4'hC;
      SEG_D:   digit_o = 4'hD;
      SEG_E:   digit_o = 4'hE;
      SEG_F:   digit_o = 4'hF;
`endif
      default: begin
        valid_o = 1'b0;
        digit_o = DIGIT_INVALID;
      end
    endcase
  end

endmodule

// File: rtl/seven_segment_decoder.sv
// Debounced seven-segment bus decoder with a one-entry valid/ready output
// register and sticky overrun flag. Hex digits via SEVEN_SEGMENT_DECODER_HEX_EN.
module seven_segment_decoder
  import seven_segment_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  input  logic       out_ready,
  input  logic       overrun_clr,
  output logic       out_valid,
  output logic [3:0] digit_out,
  output logic       invalid_out,
  output logic       overrun_out
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(STABLE_CYCLES - 1);

  decoder_state_t   state_q, state_d;
  logic [6:0]       seg_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [3:0]       digit_q, digit_d;
  logic             invalid_q, invalid_d;
  logic             overrun_q, overrun_d;

  logic             change;
  logic             emit;
  logic             xfer;
  logic             lut_valid;
  logic [3:0]       lut_digit;

  // Decode the registered pattern: it is the one that has proven stable.
  seven_segment_lut u_lut (
    .seg_i   (seg_q),
    .valid_o (lut_valid),
    .digit_o (lut_digit)
  );

  assign change = (seg_in != seg_q);

  always_comb begin
    state_d = state_q;
    emit    = 1'b0;
    cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    if (change) begin
      cnt_d   = '0;
      state_d = SETTLE;
    end else if (state_q == SETTLE && cnt_q == SETTLE_LAST) begin
      if (seg_q == SEG_BLANK) begin
        state_d = IDLE;
      end else begin
        emit    = 1'b1;
        state_d = HOLD;
      end
    end
  end

  // Output register: a new result may load only into an empty or draining slot.
  always_comb begin
    xfer        = out_valid_q & out_ready;
    out_valid_d = out_valid_q;
    digit_d     = digit_q;
    invalid_d   = invalid_q;
    overrun_d   = overrun_q & ~overrun_clr;
    if (emit && (!out_valid_q || xfer)) begin
      out_valid_d = 1'b1;
      digit_d     = lut_digit;
      invalid_d   = ~lut_valid;
    end else if (emit) begin
      overrun_d   = 1'b1;
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q       <= SEG_BLANK;
      cnt_q       <= '0;
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      digit_q     <= 4'h0;
      invalid_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      seg_q       <= seg_in;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      digit_q     <= digit_d;
      invalid_q   <= invalid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign digit_out   = digit_q;
  assign invalid_out = invalid_q;
  assign overrun_out = overrun_q;

endmodule
